// File: rtl/hdc_pkg.sv
// Shared HDC types, dataset sizes and sequencer enums.
// No logic: constants, typedefs and a small elaboration-time helper.
package hdc_pkg;

    localparam int FEATURE_COUNT             = 4;
    localparam int TRAINING_DATAPOINTS_COUNT = 3;
    localparam int TESTING_DATAPOINTS_COUNT  = 2;

    typedef logic [15:0] feature_t;
    typedef logic [4:0]  class_t;
    typedef logic [10:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAP,
        ST_DRAIN,
        ST_STROBE,
        ST_BINARIZE,
        ST_WAIT_DONE,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_TRAIN = 2'd1,
        PH_TEST  = 2'd2,
        PH_DONE  = 2'd3
    } phase_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdc_wait_counter.sv
// Down-counter for the sequencer's fixed waits; load N-1 to wait N cycles.
// Latency: expired is a decode of the count register; holds while en is low.
// Backpressure: none, en freezes the count.
module hdc_wait_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/hdc_phase_sequencer.sv
// Drives the one-shot HDC core through train/test phases; HDC_SEQ_PERF_EN adds a run-length counter.
// Latency: start_mapping and sample registers valid the cycle after the s_valid/s_ready handshake.
// Backpressure: s_ready only in LOAD with en high; en low freezes everything.
module hdc_phase_sequencer #(
    parameter int FEATURE_COUNT             = hdc_pkg::FEATURE_COUNT,
    parameter int TRAINING_DATAPOINTS_COUNT = hdc_pkg::TRAINING_DATAPOINTS_COUNT,
    parameter int TESTING_DATAPOINTS_COUNT  = hdc_pkg::TESTING_DATAPOINTS_COUNT,
    parameter int MAP_CYCLES                = 12,
    parameter int DRAIN_CYCLES              = 23,
    parameter int BINARIZE_CYCLES           = 259
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              run,
    input  logic              s_valid,
    output logic              s_ready,
    input  hdc_pkg::feature_t s_features [FEATURE_COUNT],
    input  hdc_pkg::class_t   s_label,
    output logic              start_mapping,
    output hdc_pkg::feature_t input_values [FEATURE_COUNT],
    output hdc_pkg::class_t   class_select_bits,
    output logic              training_dataset_finished,
    output logic              testing_dataset_finished,
    input  logic              core_done,
    input  hdc_pkg::count_t   core_correct,
    output logic [1:0]        phase,
    output logic              seq_done,
    output hdc_pkg::count_t   result_correct,
    output logic [31:0]       perf_cycles
);
    import hdc_pkg::*;

    localparam int WAIT_W = $clog2(max_of(MAP_CYCLES, max_of(DRAIN_CYCLES, BINARIZE_CYCLES)) + 1);
    localparam int SCNT_W = $clog2(max_of(max_of(TRAINING_DATAPOINTS_COUNT, TESTING_DATAPOINTS_COUNT), 1) + 1);

    localparam logic [WAIT_W-1:0] MAP_LD   = WAIT_W'(MAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LD = WAIT_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0] BIN_LD   = WAIT_W'(BINARIZE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] TRAIN_N  = SCNT_W'(TRAINING_DATAPOINTS_COUNT);
    localparam logic [SCNT_W-1:0] TEST_N   = SCNT_W'(TESTING_DATAPOINTS_COUNT);

    seq_state_t        state;
    phase_t            phase_q;
    logic [SCNT_W-1:0] sample_cnt;
    logic [SCNT_W-1:0] phase_total;
    logic              last_sample;
    logic              start_q;
    logic              trn_fin_q;
    logic              tst_fin_q;
    logic              wait_load;
    logic [WAIT_W-1:0] wait_val;
    logic              wait_expired;

    assign phase_total = (phase_q == PH_TRAIN) ? TRAIN_N : TEST_N;
    assign last_sample = (sample_cnt == phase_total);

    // Loads mirror the FSM transitions that enter a timed state.
    always_comb begin
        wait_load = 1'b0;
        wait_val  = MAP_LD;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (run && TRAINING_DATAPOINTS_COUNT == 0) begin
                    wait_load = 1'b1;
                    wait_val  = DRAIN_LD;
                end
            end
            ST_LOAD:     wait_load = s_valid;
            ST_MAP: begin
                if (wait_expired && last_sample) begin
                    wait_load = 1'b1;
                    wait_val  = DRAIN_LD;
                end
            end
            ST_STROBE: begin
                if (phase_q == PH_TRAIN) begin
                    wait_load = 1'b1;
                    wait_val  = BIN_LD;
                end
            end
            ST_BINARIZE: begin
                if (wait_expired && TESTING_DATAPOINTS_COUNT == 0) begin
                    wait_load = 1'b1;
                    wait_val  = DRAIN_LD;
                end
            end
            default: ;
        endcase
    end

    hdc_wait_counter #(.W(WAIT_W)) u_wait (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .load     (wait_load),
        .load_val (wait_val),
        .expired  (wait_expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= ST_IDLE;
            phase_q           <= PH_IDLE;
            sample_cnt        <= '0;
            start_q           <= 1'b0;
            trn_fin_q         <= 1'b0;
            tst_fin_q         <= 1'b0;
            seq_done          <= 1'b0;
            result_correct    <= '0;
            class_select_bits <= '0;
            for (int i = 0; i < FEATURE_COUNT; i++) input_values[i] <= '0;
        end else if (en) begin
            start_q   <= 1'b0;
            trn_fin_q <= 1'b0;
            tst_fin_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        phase_q    <= PH_TRAIN;
                        sample_cnt <= '0;
                        seq_done   <= 1'b0;
                        state      <= (TRAINING_DATAPOINTS_COUNT == 0) ? ST_DRAIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        input_values      <= s_features;
                        class_select_bits <= s_label;
                        start_q           <= 1'b1;
                        sample_cnt        <= sample_cnt + 1'b1;
                        state             <= ST_MAP;
                    end
                end
                ST_MAP: begin
                    if (wait_expired) state <= last_sample ? ST_DRAIN : ST_LOAD;
                end
                ST_DRAIN: begin
                    if (wait_expired) begin
                        trn_fin_q <= (phase_q == PH_TRAIN);
                        tst_fin_q <= (phase_q != PH_TRAIN);
                        state     <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state <= (phase_q == PH_TRAIN) ? ST_BINARIZE : ST_WAIT_DONE;
                end
                ST_BINARIZE: begin
                    if (wait_expired) begin
                        phase_q    <= PH_TEST;
                        sample_cnt <= '0;
                        state      <= (TESTING_DATAPOINTS_COUNT == 0) ? ST_DRAIN : ST_LOAD;
                    end
                end
                ST_WAIT_DONE: begin
                    if (core_done) begin
                        result_correct <= core_correct;
                        seq_done       <= 1'b1;
                        phase_q        <= PH_DONE;
                        state          <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pulses are held in their registers while en is low and surface once it returns.
    assign s_ready                   = en && (state == ST_LOAD);
    assign start_mapping             = en && start_q;
    assign training_dataset_finished = en && trn_fin_q;
    assign testing_dataset_finished  = en && tst_fin_q;
    assign phase                     = phase_q;

`ifdef HDC_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_q <= '0;
        end else if (en) begin
            if (state == ST_IDLE || state == ST_DONE) begin
                if (run) perf_q <= '0;
            end else if (perf_q != '1) begin
                perf_q <= perf_q + 1'b1;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
